// File: rtl/ebus_dev_responder_if.sv
// EBUS bundle between the EBOX (master) and one device responder (slave).
// Bit numbering follows the PDP-10 convention: bit 0 is the most significant bit.
interface ebus_dev_responder_if;
   logic [0:6]  EBUS_CS;
   logic [0:2]  EBUS_F;
   logic        EBUS_demand;
   logic [0:35] EBUS;
   logic        EBUS_xfer;
   logic [0:35] DEV_EBUS;
   logic        DEVdrivingEBUS;
   logic [1:7]  EBUS_PI;

   modport master (
      output EBUS_CS, EBUS_F, EBUS_demand, EBUS,
      input  EBUS_xfer, DEV_EBUS, DEVdrivingEBUS, EBUS_PI
   );

   modport slave (
      input  EBUS_CS, EBUS_F, EBUS_demand, EBUS,
      output EBUS_xfer, DEV_EBUS, DEVdrivingEBUS, EBUS_PI
   );
endinterface

// File: rtl/ebus_dev_responder.sv
// ebus_dev_responder: device-side EBUS responder for CONO/CONI/DATAO/DATAI.
// Holds one device's control register (conReg[18:35]), DONE flag and DATAO
// output word, and completes the demand/xfer handshake with the EBOX.
// Optional feature macro: EBUS_PI_EN -- when defined, DONE raises a PI request
// on the level held in conReg[33:35]; otherwise EBUS_PI is held at zero.
module ebus_dev_responder #(
   parameter logic [0:6] DEV_NUM    = 7'h04,
   parameter int         XFER_DELAY = 2
) (
   input  logic                  eboxClk,
   input  logic                  eboxReset,
   ebus_dev_responder_if.slave   ebus,
   input  logic [0:17]           devStatus,
   input  logic [0:35]           devDataIn,
   output logic [0:35]           devDataOut,
   output logic                  devDataStrobe,
   input  logic                  devAttn
);

   localparam int CW = (XFER_DELAY > 1) ? $clog2(XFER_DELAY) : 1;

   localparam logic [0:2] F_CONO  = 3'd0;
   localparam logic [0:2] F_CONI  = 3'd1;
   localparam logic [0:2] F_DATAO = 3'd2;
   localparam logic [0:2] F_DATAI = 3'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_XFER    = 2'd2,
      ST_RELEASE = 2'd3
   } state_e;

   // Word returned on DEV_EBUS for a read function; DONE overlays bit 32 of the CONI word.
   function automatic logic [0:35] read_word(input logic [0:2]   f,
                                             input logic [0:17]  st,
                                             input logic [18:35] con,
                                             input logic         done,
                                             input logic [0:35]  din);
      logic [0:35] w;
      w = 36'h0;
      case (f)
         F_CONI: begin
            w     = {st, con};
            w[32] = done;
         end
         F_DATAI: w = din;
         default: w = 36'h0;
      endcase
      return w;
   endfunction

   function automatic logic is_read(input logic [0:2] f);
      return (f == F_CONI) || (f == F_DATAI);
   endfunction

`ifdef EBUS_PI_EN
   // One-hot PI request on the programmed level; level 0 requests nothing.
   function automatic logic [1:7] pi_decode(input logic done, input logic [0:2] level);
      logic [1:7] pi;
      pi = 7'b0;
      if (done && (level != 3'd0)) begin
         pi[int'(level)] = 1'b1;
      end else begin
         pi = 7'b0;
      end
      return pi;
   endfunction
`endif

   state_e        state_q, state_d;
   logic [0:2]    func_q, func_d;
   logic [CW-1:0] count_q, count_d;
   logic          xfer_q, xfer_d;
   logic          drive_q, drive_d;
   logic [0:35]   dev_ebus_q, dev_ebus_d;
   logic [0:35]   data_out_q, data_out_d;
   logic          strobe_q, strobe_d;
   logic [18:35]  con_q, con_d;
   logic          done_q, done_d;
   logic [1:7]    pi_q, pi_d;
   logic          done_clr_s;
   logic          accept_s;

   assign accept_s = ebus.EBUS_demand && (ebus.EBUS_CS == DEV_NUM) && (ebus.EBUS_F <= 3'd3);

   // Next-state logic: handshake FSM, write commit and read-data sampling.
   always_comb begin
      state_d    = state_q;
      func_d     = func_q;
      count_d    = count_q;
      xfer_d     = xfer_q;
      drive_d    = drive_q;
      dev_ebus_d = dev_ebus_q;
      data_out_d = data_out_q;
      strobe_d   = 1'b0;
      con_d      = con_q;
      done_clr_s = 1'b0;

      case (state_q)
         ST_IDLE: begin
            xfer_d     = 1'b0;
            drive_d    = 1'b0;
            dev_ebus_d = 36'h0;
            if (accept_s) begin
               state_d = ST_WAIT;
               func_d  = ebus.EBUS_F;
               count_d = CW'(XFER_DELAY - 1);
               if (is_read(ebus.EBUS_F)) begin
                  drive_d    = 1'b1;
                  dev_ebus_d = read_word(ebus.EBUS_F, devStatus, con_q, done_q, devDataIn);
               end else begin
                  drive_d    = 1'b0;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_WAIT: begin
            if (!ebus.EBUS_demand) begin
               // Demand withdrawn before the acknowledge: abandon without side effects.
               state_d    = ST_IDLE;
               xfer_d     = 1'b0;
               drive_d    = 1'b0;
               dev_ebus_d = 36'h0;
            end else begin
               dev_ebus_d = read_word(func_q, devStatus, con_q, done_q, devDataIn);
               if (count_q == '0) begin
                  state_d = ST_XFER;
                  xfer_d  = 1'b1;
                  case (func_q)
                     F_CONO: begin
                        con_d      = ebus.EBUS[18:35];
                        done_clr_s = ebus.EBUS[30];
                     end
                     F_DATAO: begin
                        data_out_d = ebus.EBUS;
                        strobe_d   = 1'b1;
                     end
                     default: begin
                        con_d = con_q;
                     end
                  endcase
               end else begin
                  count_d = count_q - CW'(1);
               end
            end
         end

         ST_XFER: begin
            if (!ebus.EBUS_demand) begin
               state_d    = ST_RELEASE;
               xfer_d     = 1'b0;
               drive_d    = 1'b0;
               dev_ebus_d = 36'h0;
            end else begin
               xfer_d = 1'b1;
               // While acknowledged, only the external status/data fields may move.
               case (func_q)
                  F_CONI:  dev_ebus_d = {devStatus, dev_ebus_q[18:35]};
                  F_DATAI: dev_ebus_d = devDataIn;
                  default: dev_ebus_d = 36'h0;
               endcase
            end
         end

         ST_RELEASE: begin
            state_d    = ST_IDLE;
            xfer_d     = 1'b0;
            drive_d    = 1'b0;
            dev_ebus_d = 36'h0;
         end

         default: begin
            state_d    = ST_IDLE;
            xfer_d     = 1'b0;
            drive_d    = 1'b0;
            dev_ebus_d = 36'h0;
         end
      endcase

      // devAttn outranks a CONO clear landing on the same edge.
      if (devAttn) begin
         done_d = 1'b1;
      end else if (done_clr_s) begin
         done_d = 1'b0;
      end else begin
         done_d = done_q;
      end

`ifdef EBUS_PI_EN
      pi_d = pi_decode(done_d, con_d[33:35]);
`else
      pi_d = 7'b0;
`endif
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge eboxClk) begin
      if (eboxReset) begin
         state_q    <= ST_IDLE;
         func_q     <= 3'd0;
         count_q    <= '0;
         xfer_q     <= 1'b0;
         drive_q    <= 1'b0;
         dev_ebus_q <= 36'h0;
         data_out_q <= 36'h0;
         strobe_q   <= 1'b0;
         con_q      <= 18'h0;
         done_q     <= 1'b0;
         pi_q       <= 7'b0;
      end else begin
         state_q    <= state_d;
         func_q     <= func_d;
         count_q    <= count_d;
         xfer_q     <= xfer_d;
         drive_q    <= drive_d;
         dev_ebus_q <= dev_ebus_d;
         data_out_q <= data_out_d;
         strobe_q   <= strobe_d;
         con_q      <= con_d;
         done_q     <= done_d;
         pi_q       <= pi_d;
      end
   end

   assign ebus.EBUS_xfer      = xfer_q;
   assign ebus.DEVdrivingEBUS = drive_q;
   assign ebus.DEV_EBUS       = dev_ebus_q;
   assign ebus.EBUS_PI        = pi_q;
   assign devDataOut          = data_out_q;
   assign devDataStrobe       = strobe_q;

endmodule
